// File: rtl/dac_serializer_if.sv
// Sample-in / DAC-out signal bundle for dac_serializer.
// master: the sample source and DAC side; slave: the serializer.
interface dac_serializer_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       dac_sclk;
    logic       dac_sync_n;
    logic       dac_din;
    logic       busy;
    logic       overrun;

    modport master (
        output sample_in, sample_valid,
        input  dac_sclk, dac_sync_n, dac_din, busy, overrun
    );

    modport slave (
        input  sample_in, sample_valid,
        output dac_sclk, dac_sync_n, dac_din, busy, overrun
    );
endinterface

// File: rtl/dac_serializer.sv
// Buffers one 8-bit sample and shifts it to a serial DAC as a 16-bit frame, MSB first.
// Macro DACSER_TWOS_COMP_EN: treat samples as two's complement (bit 7 inverted at capture).
module dac_serializer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [1:0]  PD_MODE    = 2'b00
) (
    input  logic           sysclk,
    input  logic           reset,
    dac_serializer_if.slave bus
);
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned FRAME_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_DONE = BIT_W'(FRAME_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 sclk_q, sclk_d;
    logic                 sync_n_q, sync_n_d;
    logic                 din_q, din_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 drain_c;
    logic [7:0]           sample_cap_c;
    logic [FRAME_W-1:0]   frame_c;

`ifdef DACSER_TWOS_COMP_EN
    assign sample_cap_c = {~bus.sample_in[7], bus.sample_in[6:0]};
`else
    assign sample_cap_c = bus.sample_in;
`endif

    assign frame_c = {2'b00, PD_MODE, hold_q, 4'b0000};

    // State and output registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b1;
            sync_n_q    <= 1'b1;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            sync_n_q    <= sync_n_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state: frame sequencing plus hold-register bookkeeping
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        sync_n_d    = sync_n_q;
        din_d       = din_q;
        overrun_d   = 1'b0;
        drain_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    drain_c  = 1'b1;
                    shreg_d  = frame_c;
                    din_d    = frame_c[FRAME_W-1];
                    sync_n_d = 1'b0;
                    sclk_d   = 1'b1;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        bit_d = bit_q + BIT_W'(1);
                    end else if (bit_q == BITS_DONE) begin
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        state_d  = S_GAP;
                    end else begin
                        shreg_d = shreg_q << 1;
                        din_d   = shreg_d[FRAME_W-1];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                // divider is reused as the inter-frame gap counter
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.sample_valid) begin
            hold_d      = sample_cap_c;
            hold_full_d = 1'b1;
            overrun_d   = hold_full_q & ~drain_c;
        end else if (drain_c) begin
            hold_full_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.dac_sclk   = sclk_q;
    assign bus.dac_sync_n = sync_n_q;
    assign bus.dac_din    = din_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Directed self-checking bench for dac_serializer (default and CLK_DIV=1/GAP_CYCLES=1 instances).
module tb_dac_serializer;
    logic sysclk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dac_serializer_if bus ();
    dac_serializer_if bus_f ();

    dac_serializer u_dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    dac_serializer #(.CLK_DIV(1), .GAP_CYCLES(1), .PD_MODE(2'b00)) u_fast (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus_f)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Frame monitor for the default instance: records falling-edge bits and frame lengths
    logic [15:0] frames[$];
    int          lens[$];
    int          ovr_cnt = 0;
    int          sclk_edges = 0;
    int          cur_falls = 0;
    int          cur_len = 0;
    bit          in_frame = 0;
    logic        sclk_prev = 1'b1;
    logic [15:0] cur_bits = '0;

    always @(posedge sysclk) begin
        #1;
        if (!reset) begin
            in_frame  = 0;
            cur_falls = 0;
            sclk_prev = 1'b1;
        end else begin
            if (bus.overrun) ovr_cnt++;
            if (sclk_prev !== bus.dac_sclk) sclk_edges++;
            if (!bus.dac_sync_n) begin
                if (!in_frame) begin
                    in_frame  = 1;
                    cur_bits  = '0;
                    cur_len   = 0;
                    cur_falls = 0;
                end
                cur_len++;
                if (sclk_prev && !bus.dac_sclk) begin
                    cur_bits = {cur_bits[14:0], bus.dac_din};
                    cur_falls++;
                end
            end else if (in_frame) begin
                in_frame = 0;
                frames.push_back(cur_bits);
                lens.push_back(cur_len);
            end
            sclk_prev = bus.dac_sclk;
        end
    end

    function automatic logic [15:0] frame_of(input logic [7:0] s);
        logic [7:0] c;
        c = s;
`ifdef DACSER_TWOS_COMP_EN
        c[7] = ~c[7];
`endif
        return {4'b0000, c, 4'b0000};
    endfunction

    task automatic pulse(input logic [7:0] d);
        bus.sample_in    = d;
        bus.sample_valid = 1'b1;
        @(negedge sysclk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (frames.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_sync_low(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (!bus.dac_sync_n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.sample_in = '0;   bus.sample_valid = 1'b0;
        bus_f.sample_in = '0; bus_f.sample_valid = 1'b0;
        repeat (3) @(negedge sysclk);
        n_checks++; if (bus.dac_sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", bus.dac_sclk); end
        n_checks++; if (bus.dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL reset_sync_n: got %b want 1", bus.dac_sync_n); end
        n_checks++; if (bus.dac_din !== 1'b0) begin n_fail++; $display("FAIL reset_din: got %b want 0", bus.dac_din); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        n_checks++; if (bus_f.dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL reset_fast_sync_n: got %b want 1", bus_f.dac_sync_n); end
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_frame;
        int n0;
        bit ok;
        n0 = frames.size();
        pulse(8'hA5);
        n_checks++; if (bus.dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL latency_k: sync_n got %b want 1", bus.dac_sync_n); end
        @(negedge sysclk);
        n_checks++; if (bus.dac_sync_n !== 1'b0) begin n_fail++; $display("FAIL latency_k1: sync_n got %b want 0", bus.dac_sync_n); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_shift: got %b want 1", bus.busy); end
        wait_frames(n0 + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_a5_timeout: got none want 1 frame"); end
`ifdef DACSER_TWOS_COMP_EN
        n_checks++; if (frames[n0] !== 16'h0250) begin n_fail++; $display("FAIL frame_a5_bits: got %h want 0250", frames[n0]); end
`else
        n_checks++; if (frames[n0] !== 16'h0A50) begin n_fail++; $display("FAIL frame_a5_bits: got %h want 0a50", frames[n0]); end
`endif
        n_checks++; if (lens[n0] !== 64) begin n_fail++; $display("FAIL frame_a5_len: got %0d want 64", lens[n0]); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy0: got %b want 1", bus.busy); end
        @(negedge sysclk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy1: got %b want 1", bus.busy); end
        @(negedge sysclk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle: busy got %b want 0", bus.busy); end
        n_checks++; if (bus.dac_sclk !== 1'b1) begin n_fail++; $display("FAIL idle_sclk: got %b want 1", bus.dac_sclk); end
    endtask

    task automatic test_twos_comp;
        int n0;
        bit ok;
        n0 = frames.size();
        pulse(8'h80);
        wait_frames(n0 + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_80_timeout: got none want 1 frame"); end
`ifdef DACSER_TWOS_COMP_EN
        n_checks++; if (frames[n0] !== 16'h0000) begin n_fail++; $display("FAIL frame_80_bits: got %h want 0000", frames[n0]); end
`else
        n_checks++; if (frames[n0] !== 16'h0800) begin n_fail++; $display("FAIL frame_80_bits: got %h want 0800", frames[n0]); end
`endif
        wait_idle(ok);
    endtask

    task automatic test_overrun;
        int n0;
        int o0;
        bit ok;
        n0 = frames.size();
        o0 = ovr_cnt;
        pulse(8'h11);
        wait_sync_low(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_start_timeout: got none want frame start"); end
        repeat (10) @(negedge sysclk);
        pulse(8'h22);
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_on_22: got %b want 0", bus.overrun); end
        repeat (10) @(negedge sysclk);
        pulse(8'h33);
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_on_33: got %b want 1", bus.overrun); end
        wait_frames(n0 + 2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_frames_timeout: got %0d want 2 frames", frames.size() - n0); end
        n_checks++; if (frames[n0] !== 16'h0110) begin n_fail++; $display("FAIL ovr_frame0: got %h want 0110", frames[n0]); end
        n_checks++; if (frames[n0+1] !== 16'h0330) begin n_fail++; $display("FAIL ovr_frame1: got %h want 0330", frames[n0+1]); end
        wait_idle(ok);
        n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back;
        int n0;
        int o0;
        bit ok;
        n0 = frames.size();
        o0 = ovr_cnt;
        pulse(8'h3C);
        wait_sync_low(ok);
        repeat (10) @(negedge sysclk);
        pulse(8'h96);
        wait_frames(n0 + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout: got none want 1 frame"); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap0: busy got %b want 1", bus.busy); end
        @(negedge sysclk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap1: busy got %b want 1", bus.busy); end
        @(negedge sysclk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy got %b want 0", bus.busy); end
        bus.sample_in    = 8'hC3;
        bus.sample_valid = 1'b1;
        @(negedge sysclk);
        bus.sample_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", bus.busy); end
        n_checks++; if (bus.dac_sync_n !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_sync: got %b want 0", bus.dac_sync_n); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_overrun: got %b want 0", bus.overrun); end
        wait_frames(n0 + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_frames_timeout: got %0d want 3 frames", frames.size() - n0); end
        n_checks++; if (frames[n0] !== frame_of(8'h3C)) begin n_fail++; $display("FAIL b2b_frame0: got %h want %h", frames[n0], frame_of(8'h3C)); end
        n_checks++; if (frames[n0+1] !== frame_of(8'h96)) begin n_fail++; $display("FAIL b2b_frame1: got %h want %h", frames[n0+1], frame_of(8'h96)); end
        n_checks++; if (frames[n0+2] !== frame_of(8'hC3)) begin n_fail++; $display("FAIL b2b_frame2: got %h want %h", frames[n0+2], frame_of(8'hC3)); end
        wait_idle(ok);
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL b2b_ovr_count: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_reset_mid_frame;
        int n0;
        int e0;
        bit ok;
        n0 = frames.size();
        pulse(8'hE7);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sysclk);
            if (cur_falls >= 7) begin
                ok = 1;
                break;
            end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_bit7_timeout: got %0d falls want 7", cur_falls); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL midrst_sync_n: got %b want 1", bus.dac_sync_n); end
        n_checks++; if (bus.dac_sclk !== 1'b1) begin n_fail++; $display("FAIL midrst_sclk: got %b want 1", bus.dac_sclk); end
        n_checks++; if (bus.dac_din !== 1'b0) begin n_fail++; $display("FAIL midrst_din: got %b want 0", bus.dac_din); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        e0 = sclk_edges;
        repeat (100) @(negedge sysclk);
        n_checks++; if (sclk_edges - e0 !== 0) begin n_fail++; $display("FAIL midrst_no_sclk: got %0d edges want 0", sclk_edges - e0); end
        n_checks++; if (bus.dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL midrst_stay_idle: sync_n got %b want 1", bus.dac_sync_n); end
        n_checks++; if (frames.size() !== n0) begin n_fail++; $display("FAIL midrst_aborted: got %0d frames want 0", frames.size() - n0); end
        pulse(8'h5A);
        wait_frames(n0 + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_resume_timeout: got none want 1 frame"); end
        n_checks++; if (frames[n0] !== frame_of(8'h5A)) begin n_fail++; $display("FAIL midrst_resume_bits: got %h want %h", frames[n0], frame_of(8'h5A)); end
        wait_idle(ok);
    endtask

    task automatic test_fast_div;
        logic [7:0]  samples [4];
        logic [15:0] bits;
        logic        prev;
        int          low_cnt;
        int          ovr;
        samples = '{8'h3C, 8'hFF, 8'h01, 8'h80};
        for (int f = 0; f < 4; f++) begin
            bits    = '0;
            low_cnt = 0;
            ovr     = 0;
            prev    = bus_f.dac_sclk;
            bus_f.sample_in    = samples[f];
            bus_f.sample_valid = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge sysclk);
                bus_f.sample_valid = 1'b0;
                if (!bus_f.dac_sync_n) begin
                    low_cnt++;
                    if (prev && !bus_f.dac_sclk) bits = {bits[14:0], bus_f.dac_din};
                end
                if (bus_f.overrun) ovr++;
                prev = bus_f.dac_sclk;
            end
            n_checks++; if (low_cnt !== 32) begin n_fail++; $display("FAIL fast_len[%0d]: got %0d want 32", f, low_cnt); end
            n_checks++; if (bits !== frame_of(samples[f])) begin n_fail++; $display("FAIL fast_bits[%0d]: got %h want %h", f, bits, frame_of(samples[f])); end
            n_checks++; if (ovr !== 0) begin n_fail++; $display("FAIL fast_overrun[%0d]: got %0d want 0", f, ovr); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_single_frame;
        test_twos_comp;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        test_fast_div;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 2: sysclk cycles per dac_sclk half-period; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 2: sysclk cycles dac_sync_n stays high between frames; legal range 1..15.
REQ-003 Parameter PD_MODE, default 2'b00: DAC power-down bits placed in every frame.
REQ-004 sysclk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 sample_in  in  8  sample word from the channel splitter (its currentData).
REQ-007 sample_valid  in  1  one-cycle strobe; sample_in is valid while it is high (splitter outTrig).
REQ-008 dac_sclk  out  1  serial clock to the DAC; idles high.
REQ-009 dac_sync_n  out  1  frame-sync to the DAC, active-low.
REQ-010 dac_din  out  1  serial data, MSB first.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 overrun  out  1  one-cycle pulse when an unsent held sample is overwritten.

Function
REQ-013 Buffering: one 8-bit hold register with a hold_full flag.
- sample_valid=1 writes sample_in to the hold register and sets hold_full.
REQ-014 Overrun: if sample_valid=1 while hold_full=1 and the hold register is not being drained that cycle, the new sample replaces the old one and overrun pulses high for one cycle.
REQ-015 Simultaneous events: sample_valid in the same cycle the hold register drains stores the new sample, leaves hold_full=1, and raises no overrun.
REQ-016 States: IDLE, SHIFT, GAP.
REQ-017 IDLE with hold_full=1 takes these actions on the next edge:
- load the 16-bit frame {2'b00, PD_MODE, hold, 4'b0000} into the shift register;
- clear hold_full;
- drive dac_sync_n=0 and dac_din=frame[15];
- clear the divider and bit counter;
- enter SHIFT.
REQ-018 Latency: sample_valid sampled at edge k gives dac_sync_n low after edge k+1.
REQ-019 SHIFT, divider:
- a 4-bit divider counts 0..CLK_DIV-1;
- at the terminal count dac_sclk toggles and the divider clears.
REQ-020 SHIFT, bit timing: the DAC samples dac_din on the falling dac_sclk edge; dac_din shifts to the next bit on each rising toggle.
REQ-021 A 5-bit bit counter increments on each falling toggle.
REQ-022 On the first rising toggle after the 16th falling toggle:
- dac_sync_n goes to 1 and dac_sclk stays high;
- dac_din goes to 0;
- the state becomes GAP.
REQ-023 Frame length: 32*CLK_DIV sysclk cycles from dac_sync_n falling to dac_sync_n rising.
REQ-024 GAP counts GAP_CYCLES cycles, then goes to IDLE; a sample arriving during SHIFT or GAP waits in the hold register.
REQ-025 Back-to-back: if hold_full=1 on the IDLE entry cycle, the next frame starts on the following edge.

Reset
REQ-026 Reset low asynchronously forces these values:
- state IDLE; dac_sclk=1, dac_sync_n=1, dac_din=0, busy=0, overrun=0;
- hold_full=0, hold=0, shift register=0, all counters 0.
REQ-027 Reset asserted mid-frame aborts the frame immediately; after release the block waits for a new sample_valid.

Configuration
REQ-028 Macro DACSER_TWOS_COMP_EN:
- defined: sample_in is two's complement, and bit 7 of the captured sample is inverted before framing (offset-binary conversion);
- undefined: the sample is framed unchanged.

Verification
REQ-029 Defaults, sample_in=8'hA5 with one sample_valid pulse: dac_sync_n low 2 cycles later for 64 cycles; 16 falling-edge bits read 16'h0A50; then IDLE after a 2-cycle gap.
REQ-030 With DACSER_TWOS_COMP_EN defined, sample_in=8'h80: falling-edge bits read 16'h0000.
REQ-031 Pulses 8'h11 then 8'h22 during SHIFT, then 8'h33 still during the same frame: overrun pulses once (on 8'h33); the next frame carries 8'h33.
REQ-032 sample_valid in the IDLE-entry cycle after GAP: no overrun; the next frame starts on the next edge and busy does not drop for more than one cycle.
REQ-033 Reset pulled low at bit 7 of a frame: outputs hold reset values immediately (dac_sync_n=1, dac_sclk=1); no further dac_sclk edges until a new sample_valid.
REQ-034 CLK_DIV=1, GAP_CYCLES=1, continuous samples every 40 cycles: every frame is 32 cycles long and no overrun occurs.
